// File: rtl/op_sequencer_pkg.sv
// Operating-state encodings and default timing for the frame-level sequencer.
// The encodings are shared with pixel_processing, which treats OP_IDLE as unknown.
package op_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_INIT         = 2'd0,
    OP_NORMAL       = 2'd1,
    OP_CLEAR_NORMAL = 2'd2,
    OP_IDLE         = 2'd3
  } op_state_e;

  localparam int INIT_FRAMES_DEF  = 340;
  localparam int CLEAR_FRAMES_DEF = 60;
  localparam int CNT_W_DEF        = 11;

  // States that are still driving a waveform sequence.
  function automatic logic is_seq(input op_state_e s);
    return (s == OP_INIT) || (s == OP_CLEAR_NORMAL);
  endfunction

endpackage

// File: rtl/op_sequencer.sv
// Frame-level controller: INIT waveform, NORMAL and in-place CLEAR_NORMAL.
// State and count only move on frame_start so a whole frame sees one state.
module op_sequencer
  import op_sequencer_pkg::*;
#(
  parameter int INIT_FRAMES  = INIT_FRAMES_DEF,
  parameter int CLEAR_FRAMES = CLEAR_FRAMES_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             frame_start,
  input  logic             init_req,
  input  logic             clear_req,
  output logic [1:0]       op_state,
  output logic [CNT_W-1:0] op_framecount,
  output logic             vram_wr_en,
  output logic             busy,
  output logic             clear_done,
  output logic             init_done
);

  localparam logic [CNT_W-1:0] INIT_LAST  = CNT_W'(INIT_FRAMES - 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_FRAMES - 1);

  op_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             ipend_q, ipend_d;
  logic             cpend_q, cpend_d;
  // A clear folded into the running INIT, acknowledged when INIT finishes.
  logic             abs_q, abs_d;
  logic             idone_q, idone_d;
  logic             cdone_q, cdone_d;
  logic             busy_q, busy_d;
  logic             vram_q, vram_d;

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ipend_d = ipend_q | init_req;
    cpend_d = cpend_q | clear_req;
    abs_d   = abs_q;
    idone_d = 1'b0;
    cdone_d = 1'b0;
    if (frame_start) begin
      if (!en) begin
        state_d = OP_IDLE;
        cnt_d   = '0;
        ipend_d = 1'b0;
        cpend_d = 1'b0;
        abs_d   = 1'b0;
      end else if (state_q == OP_IDLE || ipend_d) begin
        // Restart INIT; any outstanding or interrupted clear rides along with it.
        state_d = OP_INIT;
        cnt_d   = '0;
        ipend_d = 1'b0;
        abs_d   = abs_q | cpend_d | (state_q == OP_CLEAR_NORMAL);
        cpend_d = 1'b0;
      end else begin
        unique case (state_q)
          OP_INIT: begin
            if (cnt_q == INIT_LAST) begin
              state_d = OP_NORMAL;
              cnt_d   = '0;
              idone_d = 1'b1;
              cdone_d = abs_q | cpend_d;
              abs_d   = 1'b0;
            end else begin
              cnt_d = cnt_inc;
              abs_d = abs_q | cpend_d;
            end
            cpend_d = 1'b0;
          end
          OP_CLEAR_NORMAL: begin
            if (cnt_q == CLEAR_LAST) begin
              state_d = OP_NORMAL;
              cnt_d   = '0;
              cdone_d = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
            cpend_d = 1'b0;
          end
          OP_NORMAL: begin
            cnt_d = '0;
            if (cpend_d) begin
              state_d = OP_CLEAR_NORMAL;
              cpend_d = 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
    busy_d = is_seq(state_d) | ipend_d | cpend_d;
    vram_d = (state_d != OP_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= OP_IDLE;
      cnt_q   <= '0;
      ipend_q <= 1'b0;
      cpend_q <= 1'b0;
      abs_q   <= 1'b0;
      idone_q <= 1'b0;
      cdone_q <= 1'b0;
      busy_q  <= 1'b0;
      vram_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ipend_q <= ipend_d;
      cpend_q <= cpend_d;
      abs_q   <= abs_d;
      idone_q <= idone_d;
      cdone_q <= cdone_d;
      busy_q  <= busy_d;
      vram_q  <= vram_d;
    end
  end

  assign op_state      = state_q;
  assign op_framecount = cnt_q;
  assign vram_wr_en    = vram_q;
  assign busy          = busy_q;
  assign clear_done    = cdone_q;
  assign init_done     = idone_q;

endmodule

// File: tb/tb_op_sequencer.sv
// Directed bench for op_sequencer: INIT/NORMAL/CLEAR sequencing, request merging,
// enable abort and async reset, against hand-derived expectations.
module tb_op_sequencer;

  localparam int CNT_W = 11;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             frame_start = 1'b0;
  logic             init_req = 1'b0;
  logic             clear_req = 1'b0;
  logic [1:0]       op_state;
  logic [CNT_W-1:0] op_framecount;
  logic             vram_wr_en, busy, clear_done, init_done;

  int n_chk  = 0;
  int n_pass = 0;
  int n_idone, n_cdone;
  logic idone_s, cdone_s;

  op_sequencer #(.INIT_FRAMES(340), .CLEAR_FRAMES(60), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .frame_start(frame_start),
    .init_req(init_req), .clear_req(clear_req),
    .op_state(op_state), .op_framecount(op_framecount),
    .vram_wr_en(vram_wr_en), .busy(busy),
    .clear_done(clear_done), .init_done(init_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // {state, count} packed for compact comparisons
  function automatic logic [31:0] sc(input logic [1:0] s, input int c);
    return {19'd0, s, CNT_W'(c)};
  endfunction

  // One frame: pulse frame_start (optionally with requests), capture done pulses.
  task automatic frame(input logic creq = 1'b0, input logic ireq = 1'b0);
    @(negedge clk);
    frame_start = 1'b1; clear_req = creq; init_req = ireq;
    @(negedge clk);
    frame_start = 1'b0; clear_req = 1'b0; init_req = 1'b0;
    idone_s = init_done;
    cdone_s = clear_done;
    n_idone += int'(init_done);
    n_cdone += int'(clear_done);
    @(negedge clk);
  endtask

  task automatic pulse(input logic creq, input logic ireq);
    @(negedge clk);
    clear_req = creq; init_req = ireq;
    @(negedge clk);
    clear_req = 1'b0; init_req = 1'b0;
  endtask

  int idone_frame;

  initial begin
    // ---- reset state
    #12;
    chk("rst_state", sc(op_state, op_framecount), sc(2'd3, 0));
    chk("rst_vram", vram_wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", {init_done, clear_done}, 0);
    @(negedge clk); rst = 1'b0; en = 1'b1;

    // ---- T1: power-up INIT over 340 frames then NORMAL
    n_idone = 0; n_cdone = 0; idone_frame = -1;
    for (int k = 1; k <= 345; k++) begin
      frame();
      if (idone_s) idone_frame = k;
      if (k <= 340) begin
        chk("t1_init", sc(op_state, op_framecount), sc(2'd0, k - 1));
        if (k == 1 || k == 340) chk("t1_busy", {busy, vram_wr_en}, 2'b11);
      end else begin
        chk("t1_norm", sc(op_state, op_framecount), sc(2'd1, 0));
      end
    end
    chk("t1_idone_cnt", n_idone, 1);
    chk("t1_idone_at", idone_frame, 341);
    chk("t1_cdone_cnt", n_cdone, 0);
    chk("t1_busy_norm", busy, 0);

    // ---- T2: mid-frame clear_req in NORMAL -> 60-frame CLEAR
    n_cdone = 0;
    pulse(1'b1, 1'b0);
    chk("t2_busy_pend", busy, 1);
    chk("t2_hold", sc(op_state, op_framecount), sc(2'd1, 0));
    for (int k = 0; k < 60; k++) begin
      frame();
      chk("t2_clear", sc(op_state, op_framecount), sc(2'd2, k));
    end
    chk("t2_no_early_done", n_cdone, 0);
    frame();
    chk("t2_end", sc(op_state, op_framecount), sc(2'd1, 0));
    chk("t2_cdone_now", cdone_s, 1);
    chk("t2_cdone_cnt", n_cdone, 1);
    chk("t2_busy_end", busy, 0);

    // ---- T3: clear_req with frame_start, second request merged
    n_cdone = 0;
    frame(1'b1, 1'b0);
    chk("t3_enter", sc(op_state, op_framecount), sc(2'd2, 0));
    for (int k = 1; k <= 10; k++) frame();
    chk("t3_cnt10", sc(op_state, op_framecount), sc(2'd2, 10));
    pulse(1'b1, 1'b0);
    for (int k = 11; k < 60; k++) frame();
    chk("t3_cnt59", sc(op_state, op_framecount), sc(2'd2, 59));
    frame();
    chk("t3_end", sc(op_state, op_framecount), sc(2'd1, 0));
    for (int k = 0; k < 3; k++) frame();
    chk("t3_no_extra", sc(op_state, op_framecount), sc(2'd1, 0));
    chk("t3_cdone_cnt", n_cdone, 1);

    // ---- T6a: init_req in NORMAL restarts INIT
    pulse(1'b0, 1'b1);
    chk("t6_ipend_busy", busy, 1);
    frame();
    chk("t6_restart", sc(op_state, op_framecount), sc(2'd0, 0));

    // ---- T4: clear_req at INIT cnt=100 absorbed, acked at INIT end
    n_idone = 0; n_cdone = 0;
    for (int k = 1; k <= 100; k++) frame();
    chk("t4_cnt100", sc(op_state, op_framecount), sc(2'd0, 100));
    pulse(1'b1, 1'b0);
    chk("t4_busy_req", busy, 1);
    for (int k = 101; k <= 339; k++) begin
      frame();
      chk("t4_init", {busy, sc(op_state, op_framecount)}, {1'b1, sc(2'd0, k)});
    end
    frame();
    chk("t4_end", sc(op_state, op_framecount), sc(2'd1, 0));
    chk("t4_dones", {idone_s, cdone_s}, 2'b11);
    chk("t4_counts", {n_idone[3:0], n_cdone[3:0]}, 8'h11);
    frame();
    chk("t4_no_clear", sc(op_state, op_framecount), sc(2'd1, 0));

    // ---- T5: en low at CLEAR cnt=20 aborts to IDLE
    n_cdone = 0;
    pulse(1'b1, 1'b0);
    frame();
    for (int k = 1; k <= 20; k++) frame();
    chk("t5_cnt20", sc(op_state, op_framecount), sc(2'd2, 20));
    @(negedge clk); en = 1'b0;
    @(negedge clk);
    chk("t5_hold", sc(op_state, op_framecount), sc(2'd2, 20));
    frame();
    chk("t5_idle", sc(op_state, op_framecount), sc(2'd3, 0));
    chk("t5_vram", {vram_wr_en, busy, cdone_s}, 3'b000);
    chk("t5_cdone_cnt", n_cdone, 0);
    en = 1'b1;
    frame();
    chk("t5_reinit", sc(op_state, op_framecount), sc(2'd0, 0));
    chk("t5_vram_on", vram_wr_en, 1);

    // ---- T6b: async reset mid-INIT, no clock edge needed
    for (int k = 1; k <= 5; k++) frame();
    chk("t6_cnt5", sc(op_state, op_framecount), sc(2'd0, 5));
    @(negedge clk); #1 rst = 1'b1;
    #2;
    chk("t6_async", sc(op_state, op_framecount), sc(2'd3, 0));
    chk("t6_async_out", {vram_wr_en, busy}, 2'b00);
    @(negedge clk); rst = 1'b0;
    frame();
    chk("t6_after_rst", sc(op_state, op_framecount), sc(2'd0, 0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
